servo_pulse_gen: RTL and testbench

Downstream stage of the shutter motor controller. Takes the 8-bit servo position command and produces the RC servo PWM: one pulse per fixed frame, width linear in position. New positions are accepted through a valid strobe and applied only at frame boundaries, so pulses are never truncated or glitched. Position in effect and frame timing are exported for HEX display and for timing the controller's wait states.

---
 rtl/servo_pkg.sv | 27 ++
 rtl/servo_slew_limit.sv | 27 ++
 rtl/servo_pulse_gen.sv | 120 ++++++++++++
 tb/tb_servo_pulse_gen.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants, state encoding and the pulse-width helper for the servo PWM generator.
package servo_pkg;

  localparam int unsigned CNT_W = 20;
  localparam int unsigned POS_W = 8;

  localparam int unsigned FRAME_CYC_DEF = 1000000;
  localparam int unsigned MIN_CYC_DEF   = 50000;
  localparam int unsigned STEP_CYC_DEF  = 196;

  localparam logic [POS_W-1:0] POS_HALT      = 8'h50;
  localparam logic [POS_W-1:0] SLEW_STEP_DEF = 8'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  // Pulse width in clock cycles for a given position, in counter-width arithmetic.
  function automatic logic [CNT_W-1:0] calc_width(input logic [POS_W-1:0] pos,
                                                   input int unsigned      min_cyc,
                                                   input int unsigned      step_cyc);
    return CNT_W'(min_cyc) + CNT_W'(pos) * CNT_W'(step_cyc);
  endfunction

endpackage

// File: rtl/servo_slew_limit.sv
// Next-position function: moves cur toward target by at most step, landing exactly on target.
module servo_slew_limit
  import servo_pkg::*;
(
  input  logic [POS_W-1:0] i_cur,
  input  logic [POS_W-1:0] i_target,
  input  logic [POS_W-1:0] i_step,
  output logic [POS_W-1:0] o_next_c
);

  logic [POS_W-1:0] w_up_diff;
  logic [POS_W-1:0] w_dn_diff;

  assign w_up_diff = i_target - i_cur;
  assign w_dn_diff = i_cur - i_target;

  // Stepping only ever lands between cur and target, so 8'h00/8'hFF never wrap.
  always_comb begin
    o_next_c = i_target;
    if (i_target > i_cur) begin
      if (w_up_diff > i_step) o_next_c = i_cur + i_step;
    end else begin
      if (w_dn_diff > i_step) o_next_c = i_cur - i_step;
    end
  end

endmodule

// File: rtl/servo_pulse_gen.sv
// RC servo PWM generator: one pulse per frame, width linear in position, updates only at frame loads.
// Optional build macro SERVO_SLEW_EN limits the per-frame position change to SLEW_STEP.
module servo_pulse_gen
  import servo_pkg::*;
#(
  parameter int unsigned      FRAME_CYC = FRAME_CYC_DEF,
  parameter int unsigned      MIN_CYC   = MIN_CYC_DEF,
  parameter int unsigned      STEP_CYC  = STEP_CYC_DEF,
  parameter logic [POS_W-1:0] RESET_POS = POS_HALT,
  parameter logic [POS_W-1:0] SLEW_STEP = SLEW_STEP_DEF
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             enable,
  input  logic [POS_W-1:0] pos_in,
  input  logic             pos_valid,
  output logic             pwm,
  output logic             frame_start,
  output logic [POS_W-1:0] cur_pos,
  output logic             pulse_active
);

  if (MIN_CYC + 255 * STEP_CYC >= FRAME_CYC) begin : g_bad_width
    $error("servo_pulse_gen: widest pulse does not fit inside the frame");
  end
  if (FRAME_CYC > (1 << CNT_W) || MIN_CYC == 0) begin : g_bad_frame
    $error("servo_pulse_gen: frame must fit the counter and pulses must be non-empty");
  end
  // A zero step would pin the position forever once slewing is built in; reject it in every build.
  if (SLEW_STEP == '0) begin : g_bad_slew
    $error("servo_pulse_gen: SLEW_STEP must be non-zero");
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_width;
  logic [POS_W-1:0] r_pending;
  logic [POS_W-1:0] r_cur_pos;
  logic             r_pwm;
  logic             r_frame_start;

  logic [POS_W-1:0] w_next_pos;
  logic [CNT_W-1:0] w_next_width;
  logic             w_pulse_end;
  logic             w_frame_end;
  logic             w_load;

`ifdef SERVO_SLEW_EN
  servo_slew_limit u_slew (
    .i_cur    (r_cur_pos),
    .i_target (r_pending),
    .i_step   (SLEW_STEP),
    .o_next_c (w_next_pos)
  );
`else
  assign w_next_pos = r_pending;
`endif

  assign w_next_width = calc_width(w_next_pos, MIN_CYC, STEP_CYC);
  assign w_pulse_end  = (r_cnt == r_width - CNT_W'(1));
  assign w_frame_end  = (r_cnt == CNT_W'(FRAME_CYC - 1));
  // Frames start from idle or chain directly off the last low cycle, with no gap.
  assign w_load       = enable && ((r_state == S_IDLE) || ((r_state == S_LOW) && w_frame_end));

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_width       <= '0;
      r_pending     <= RESET_POS;
      r_cur_pos     <= RESET_POS;
      r_pwm         <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (pos_valid) r_pending <= pos_in;
      if (w_load) begin
        r_state       <= S_HIGH;
        r_cnt         <= '0;
        r_cur_pos     <= w_next_pos;
        r_width       <= w_next_width;
        r_pwm         <= 1'b1;
        r_frame_start <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
          end
          S_HIGH: begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_pulse_end) begin
              r_pwm   <= 1'b0;
              r_state <= S_LOW;
            end
          end
          S_LOW: begin
            if (w_frame_end) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pwm   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pwm          = r_pwm;
  assign pulse_active = r_pwm;
  assign frame_start  = r_frame_start;
  assign cur_pos      = r_cur_pos;

endmodule

// File: tb/tb_servo_pulse_gen.sv
// Self-checking bench for servo_pulse_gen with a frame-level reference model (FRAME=1000, MIN=50, STEP=1).
module tb_servo_pulse_gen;

  localparam int FRAME    = 1000;
  localparam int MINC     = 50;
  localparam int STEPC    = 1;
  localparam int MAX_WAIT = 2 * FRAME + 20;

  logic       clk_50    = 1'b0;
  logic       reset     = 1'b0;
  logic       enable    = 1'b0;
  logic [7:0] pos_in    = 8'h00;
  logic       pos_valid = 1'b0;
  logic       pwm;
  logic       frame_start;
  logic [7:0] cur_pos;
  logic       pulse_active;

  int total = 0;
  int bad   = 0;

  int         cyc_no  = 0;
  int         run_len = 0;
  int         fs_cyc[$];
  logic [7:0] fs_cur[$];
  int         runs[$];

  logic [7:0] exp_cur  = 8'h50;
  logic [7:0] exp_pend = 8'h50;

  servo_pulse_gen #(
    .FRAME_CYC (FRAME),
    .MIN_CYC   (MINC),
    .STEP_CYC  (STEPC)
  ) dut (
    .clk_50       (clk_50),
    .reset        (reset),
    .enable       (enable),
    .pos_in       (pos_in),
    .pos_valid    (pos_valid),
    .pwm          (pwm),
    .frame_start  (frame_start),
    .cur_pos      (cur_pos),
    .pulse_active (pulse_active)
  );

  always #10 clk_50 = ~clk_50;

  // Records frame starts and completed high-pulse lengths, one sample per cycle.
  initial forever begin
    @(posedge clk_50);
    #1;
    cyc_no++;
    if (frame_start === 1'b1) begin
      fs_cyc.push_back(cyc_no);
      fs_cur.push_back(cur_pos);
    end
    if (pwm === 1'b1) run_len++;
    else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
  end

  function automatic logic [7:0] m_next(input logic [7:0] cur, input logic [7:0] tgt);
`ifdef SERVO_SLEW_EN
    int d;
    d = int'(tgt) - int'(cur);
    if (d > 4) d = 4;
    if (d < -4) d = -4;
    return 8'(int'(cur) + d);
`else
    return tgt;
`endif
  endfunction

  function automatic int m_width(input logic [7:0] p);
    return MINC + int'(p) * STEPC;
  endfunction

  task automatic m_load();
    exp_cur = m_next(exp_cur, exp_pend);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #2;
    end
  endtask

  task automatic clear_q();
    fs_cyc.delete();
    fs_cur.delete();
    runs.delete();
  endtask

  // Waits (bounded) for the next frame start; returns at cycle 0 of that frame.
  task automatic align(output bit ok);
    clear_q();
    ok = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      tick(1);
      if (fs_cyc.size() != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Drives cycles 1..FRAME-1 of a frame; at1/at2 (0 = unused) are cycles where pos_valid is sampled.
  task automatic run_frame(input int at1, input logic [7:0] p1, input int at2, input logic [7:0] p2);
    for (int c = 1; c < FRAME; c++) begin
      pos_valid = 1'b0;
      if (c == at1) begin pos_in = p1; pos_valid = 1'b1; exp_pend = p1; end
      if (c == at2) begin pos_in = p2; pos_valid = 1'b1; exp_pend = p2; end
      tick(1);
    end
    pos_valid = 1'b0;
  endtask

  function automatic int first_run();
    return (runs.size() > 0) ? runs[0] : -1;
  endfunction

  function automatic logic [7:0] first_cur();
    return (fs_cur.size() > 0) ? fs_cur[0] : 8'hxx;
  endfunction

  task automatic test_reset();
    int rel;
    int got;
    enable = 1'b1; reset = 1'b0; pos_valid = 1'b1; pos_in = 8'hA5;
    tick(3);
    total++; if (pwm !== 1'b0) begin bad++; $display("FAIL reset_pwm: got %b want 0", pwm); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    total++; if (pulse_active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", pulse_active); end
    total++; if (cur_pos !== 8'h50) begin bad++; $display("FAIL reset_cur: got %h want 50", cur_pos); end
    pos_valid = 1'b0;
    clear_q();
    rel = cyc_no;
    exp_cur = 8'h50; exp_pend = 8'h50;
    reset = 1'b1;
    tick(1);
    m_load();
    got = (fs_cyc.size() > 0) ? fs_cyc[0] : -1;
    total++; if (got != rel + 1) begin bad++; $display("FAIL first_fs_cycle: got %0d want %0d", got, rel + 1); end
    total++; if (pwm !== 1'b1 || cur_pos !== 8'h50) begin
      bad++; $display("FAIL first_frame_out: got pwm=%b cur=%h want pwm=1 cur=50", pwm, cur_pos);
    end
    tick(FRAME);
    got = (fs_cyc.size() > 1) ? fs_cyc[1] - fs_cyc[0] : -1;
    total++; if (got != FRAME) begin bad++; $display("FAIL first_period: got %0d want %0d", got, FRAME); end
    total++; if (first_run() != 130) begin bad++; $display("FAIL first_width: got %0d want 130", first_run()); end
    m_load();
    total++; if (fs_cur.size() < 2 || fs_cur[1] !== exp_cur) begin
      bad++; $display("FAIL second_cur: got %h want %h", (fs_cur.size() > 1) ? fs_cur[1] : 8'hxx, exp_cur);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    m_load(); align(ok);
    total++; if (!ok || first_cur() !== exp_cur) begin bad++; $display("FAIL drop_start: ok=%b got %h want %h", ok, first_cur(), exp_cur); end
    tick(59);
    enable = 1'b0;
    tick(FRAME - 60);
    total++; if (first_run() != m_width(exp_cur) || pwm !== 1'b0) begin
      bad++; $display("FAIL drop_width: got %0d pwm=%b want %0d pwm=0", first_run(), pwm, m_width(exp_cur));
    end
    clear_q();
    tick(1);
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL drop_no_fs: got %b want 0", frame_start); end
    tick(100);
    total++; if (fs_cyc.size() != 0 || runs.size() != 0 || run_len != 0 || pwm !== 1'b0) begin
      bad++; $display("FAIL drop_idle: fs=%0d runs=%0d pwm=%b want 0 0 0", fs_cyc.size(), runs.size(), pwm);
    end
    enable = 1'b1;
    tick(1);
    m_load();
    total++; if (frame_start !== 1'b1 || cur_pos !== exp_cur) begin
      bad++; $display("FAIL drop_restart: fs=%b cur=%h want 1 %h", frame_start, cur_pos, exp_cur);
    end
  endtask

  task automatic test_pos_update();
    bit ok;
    int t0;
    logic [7:0] prev;
    m_load(); align(ok);
    t0 = (fs_cyc.size() > 0) ? fs_cyc[0] : 0;
    total++; if (!ok || first_cur() !== exp_cur) begin bad++; $display("FAIL upd_start: got %h want %h", first_cur(), exp_cur); end
    prev = exp_cur;
    run_frame(500, 8'hFF, 0, 8'h00);
    total++; if (first_run() != m_width(prev)) begin bad++; $display("FAIL upd_cur_width: got %0d want %0d", first_run(), m_width(prev)); end
    m_load(); align(ok);
    total++; if (!ok || first_cur() !== exp_cur || fs_cyc[0] - t0 != FRAME) begin
      bad++; $display("FAIL upd_next_cur: got %h want %h", first_cur(), exp_cur);
    end
    run_frame(0, 8'h00, 0, 8'h00);
    total++; if (first_run() != m_width(exp_cur)) begin bad++; $display("FAIL upd_next_width: got %0d want %0d", first_run(), m_width(exp_cur)); end
  endtask

  task automatic test_same_cycle();
    bit ok;
    m_load(); align(ok);
    run_frame(0, 8'h00, 0, 8'h00);
    clear_q();
    pos_in = 8'h00; pos_valid = 1'b1;
    tick(1);
    pos_valid = 1'b0;
    m_load();
    exp_pend = 8'h00;
    total++; if (frame_start !== 1'b1 || cur_pos !== exp_cur) begin
      bad++; $display("FAIL same_cycle_old: fs=%b cur=%h want 1 %h", frame_start, cur_pos, exp_cur);
    end
    run_frame(0, 8'h00, 0, 8'h00);
    total++; if (first_run() != m_width(exp_cur)) begin bad++; $display("FAIL same_cycle_width: got %0d want %0d", first_run(), m_width(exp_cur)); end
    m_load(); align(ok);
    total++; if (!ok || first_cur() !== exp_cur) begin bad++; $display("FAIL same_cycle_new: got %h want %h", first_cur(), exp_cur); end
    run_frame(0, 8'h00, 0, 8'h00);
    total++; if (first_run() != m_width(exp_cur)) begin bad++; $display("FAIL same_cycle_nwidth: got %0d want %0d", first_run(), m_width(exp_cur)); end
  endtask

  task automatic test_random();
    bit ok;
    int t_prev;
    int a1;
    int a2;
    int w;
    m_load(); align(ok);
    t_prev = (fs_cyc.size() > 0) ? fs_cyc[0] : 0;
    for (int i = 0; i < 6; i++) begin
      a1 = int'($urandom_range(FRAME - 1, 1));
      a2 = ($urandom_range(1, 0) == 1) ? int'($urandom_range(FRAME - 1, 1)) : 0;
      w  = m_width(exp_cur);
      run_frame(a1, 8'($urandom), a2, 8'($urandom));
      total++; if (first_run() != w) begin bad++; $display("FAIL rand_width[%0d]: got %0d want %0d", i, first_run(), w); end
      m_load(); align(ok);
      total++; if (!ok || first_cur() !== exp_cur || fs_cyc[0] - t_prev != FRAME) begin
        bad++; $display("FAIL rand_frame[%0d]: ok=%b cur=%h want %h", i, ok, first_cur(), exp_cur);
      end
      t_prev = (fs_cyc.size() > 0) ? fs_cyc[0] : t_prev;
    end
  endtask

`ifdef SERVO_SLEW_EN
  task automatic test_slew();
    bit ok;
    logic [7:0] want[3];
    want[0] = 8'h54; want[1] = 8'h58; want[2] = 8'h5A;
    reset = 1'b0;
    tick(2);
    clear_q();
    exp_cur = 8'h50; exp_pend = 8'h50;
    reset = 1'b1;
    tick(1);
    m_load();
    total++; if (cur_pos !== 8'h50) begin bad++; $display("FAIL slew_start: got %h want 50", cur_pos); end
    run_frame(10, 8'h5A, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      m_load(); align(ok);
      total++; if (!ok || first_cur() !== want[i]) begin bad++; $display("FAIL slew_up[%0d]: got %h want %h", i, first_cur(), want[i]); end
    end
    pos_in = 8'h03; pos_valid = 1'b1; tick(1); pos_valid = 1'b0; exp_pend = 8'h03;
    for (int i = 0; i < 30 && exp_cur != 8'h03; i++) begin
      m_load(); align(ok);
      total++; if (!ok || first_cur() !== exp_cur) begin bad++; $display("FAIL slew_down[%0d]: got %h want %h", i, first_cur(), exp_cur); end
    end
    pos_in = 8'h02; pos_valid = 1'b1; tick(1); pos_valid = 1'b0; exp_pend = 8'h02;
    m_load(); align(ok);
    total++; if (!ok || first_cur() !== 8'h02) begin bad++; $display("FAIL slew_exact: got %h want 02", first_cur()); end
    pos_in = 8'h00; pos_valid = 1'b1; tick(1); pos_valid = 1'b0; exp_pend = 8'h00;
    m_load(); align(ok);
    total++; if (!ok || first_cur() !== 8'h00) begin bad++; $display("FAIL slew_floor: got %h want 00", first_cur()); end
  endtask
`endif

  task automatic test_reset_mid_pulse();
    bit ok;
    m_load(); align(ok);
    total++; if (!ok || first_cur() !== exp_cur) begin bad++; $display("FAIL rmid_start: got %h want %h", first_cur(), exp_cur); end
    tick(20);
    total++; if (pwm !== 1'b1) begin bad++; $display("FAIL rmid_pre: got pwm=%b want 1", pwm); end
    reset = 1'b0;
    #1;
    total++; if (pwm !== 1'b0 || pulse_active !== 1'b0 || cur_pos !== 8'h50) begin
      bad++; $display("FAIL rmid_async: pwm=%b act=%b cur=%h want 0 0 50", pwm, pulse_active, cur_pos);
    end
    tick(3);
    total++; if (pwm !== 1'b0 || frame_start !== 1'b0 || cur_pos !== 8'h50) begin
      bad++; $display("FAIL rmid_hold: pwm=%b fs=%b cur=%h want 0 0 50", pwm, frame_start, cur_pos);
    end
    clear_q();
    exp_cur = 8'h50; exp_pend = 8'h50;
    reset = 1'b1;
    tick(1);
    total++; if (frame_start !== 1'b1 || pwm !== 1'b1 || cur_pos !== 8'h50) begin
      bad++; $display("FAIL rmid_restart: fs=%b pwm=%b cur=%h want 1 1 50", frame_start, pwm, cur_pos);
    end
  endtask

  initial begin
    test_reset();
    test_enable_drop();
    test_pos_update();
    test_same_cycle();
    test_random();
`ifdef SERVO_SLEW_EN
    test_slew();
`endif
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
